uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (parity → frame → baud → PISO chain) among N requesters.
- Round-robin arbitration; each requester supplies one byte plus frame config (data length, parity type, stop bits).
- Drives the transmitter's send and config inputs, holds them stable for the whole frame, and returns a one-cycle ack to the winner on tx_done.
- Sits between client logic and the UART TX top level, in the clk domain.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ID_W, 2: grant index width, equal to clog2(N_REQ).
- TIMEOUT_CYC, 65535: clk cycles allowed per frame before abort (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level; held until ack.
- req_data  in  8*N_REQ  byte for requester i at [8i+7:8i].
- req_cfg  in  4*N_REQ  per requester {data_length, stop_bits, parity_type[1:0]}.
- ack  out  N_REQ  one-cycle pulse: frame for requester i completed.
- busy  out  1  high from grant until ack/abort.
- grant_id  out  ID_W  index of the current or last owner.
- tx_send  out  1  to UART send.
- tx_data  out  8  to UART data_in.
- tx_parity_type  out  2.
- tx_data_length  out  1.
- tx_stop_bits  out  1.
- tx_active  in  1  from the PISO (baud_out domain).
- tx_done  in  1  from the PISO (baud_out domain).
- err  out  1  timeout abort pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer = 0.
- tx_active and tx_done each pass through a 2-flop synchronizer. done_rise = rising edge of the synchronized tx_done.
- IDLE: if any req, go to GRANT next cycle; otherwise stay.
- GRANT, 1 cycle:
  - Pick the first set req at or after the pointer, wrapping modulo N_REQ.
  - Latch grant_id, that requester's req_data, and its req_cfg into tx_* registers.
  - busy = 1. Go to SEND.
  - If req dropped meanwhile (no bits set), return to IDLE with busy = 0.
- SEND:
  - tx_send = 1; tx_* held constant.
  - Go to WAIT when synchronized tx_active = 1.
- WAIT:
  - tx_send stays 1.
  - On done_rise, go to RELEASE.
- RELEASE, 1 cycle:
  - tx_send = 0; ack[grant_id] = 1; busy = 0.
  - Pointer = grant_id + 1 (wrap to 0 past N_REQ-1).
  - Go to HOLDOFF.
- HOLDOFF:
  - tx_send = 0; wait until synchronized tx_active = 0 and tx_done = 0.
  - This guarantees the PISO sees send low, so the frame is not re-sent.
  - Then go to IDLE.
- Latency: req to tx_send = 2 clk cycles from IDLE.
- Config/data changes on req_* after GRANT are ignored until the next grant.
- A requester whose req falls during SEND/WAIT still completes and still receives ack.
- Simultaneous requests: round-robin only; no requester is granted twice while another is pending.
- N_REQ=1 degenerates to a pass-through with handshake.
- Async reset mid-frame returns to IDLE immediately with tx_send = 0, and no ack is issued.
- ack and err are never asserted in the same cycle.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on GRANT and increments in SEND/WAIT.
  - When it reaches TIMEOUT_CYC, go to HOLDOFF with tx_send = 0, err = 1 for one cycle, no ack, and pointer advanced past grant_id.
- Undefined: no counter; err tied 0; WAIT waits indefinitely.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum: IDLE, GRANT, SEND, WAIT, RELEASE, HOLDOFF.
  - cfg field offsets: CFG_PAR_LO=0, CFG_STOP=2, CFG_LEN=3.
  - Parity-type encodings.
- One sub-module: uart_rr_pick.
  - Combinational round-robin picker: inputs req and pointer; outputs found and index.
  - Reusable by any later multi-client UART block.
- The synchronizers are inline.

Test Plan:
- Single requester: req=4'b0001, data 8'h0F, cfg 4'b1100 → tx_send high 2 cycles after req, tx_data=8'h0F, tx_data_length=1, tx_stop_bits=1, tx_parity_type=00; one ack[0] pulse after tx_done; tx_send low during ack.
- All four requesting at once (bytes 8'hA0..8'hA3) → grants in order 0,1,2,3; each tx_data matches its owner; exactly one ack per requester.
- Pointer wrap: after serving 3, assert req=4'b1001 → grant 0 next, then 3.
- Requester 1 changes req_data from 8'h55 to 8'hAA mid-frame → tx_data stays 8'h55 until ack.
- Reset pulled low during WAIT → tx_send=0, busy=0, no ack; after release, a pending req is regranted from pointer 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=100, tx_done held 0 → err pulse at cycle 100 after GRANT, no ack, next requester granted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the multi-client UART transmit path:
// arbiter FSM states, req_cfg field offsets and parity-type encodings.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      SEND    = 3'd2,
      WAIT    = 3'd3,
      RELEASE = 3'd4,
      HOLDOFF = 3'd5
   } arb_state_e;

   // Per-requester 4-bit cfg word: {data_length, stop_bits, parity_type[1:0]}
   localparam int CFG_PAR_LO = 0;
   localparam int CFG_STOP   = 2;
   localparam int CFG_LEN    = 3;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_ODD  = 2'b01,
      PAR_EVEN = 2'b10,
      PAR_MARK = 2'b11
   } parity_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping modulo N_REQ. Usable by any multi-client UART block.
module uart_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   // Scan from the farthest offset back toward ptr so the nearest set request wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N_REQ]) begin
            found = 1'b1;
            idx   = ID_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ clients.
// Optional frame timeout abort: define UART_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner; wait for any req
// GRANT   | pick winner, latch its byte and cfg into tx_* registers
// SEND    | tx_send high, wait for synchronized tx_active
// WAIT    | tx_send high, wait for rising edge of synchronized tx_done
// RELEASE | one cycle: ack to owner, tx_send low, pointer advanced
// HOLDOFF | tx_send low until PISO shows inactive and not done
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [4*N_REQ-1:0] req_cfg,
   output logic [N_REQ-1:0]   ack,
   output logic               busy,
   output logic [ID_W-1:0]    grant_id,
   output logic               tx_send,
   output logic [7:0]         tx_data,
   output logic [1:0]         tx_parity_type,
   output logic               tx_data_length,
   output logic               tx_stop_bits,
   input  logic               tx_active,
   input  logic               tx_done,
   output logic               err
);

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic              tx_send_q, tx_send_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [1:0]        tx_par_q, tx_par_d;
   logic              tx_len_q, tx_len_d;
   logic              tx_stop_q, tx_stop_d;
   logic              busy_q, busy_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              err_q, err_d;

   logic act_s1_q, act_s2_q;
   logic done_s1_q, done_s2_q, done_s3_q;
   logic done_rise;

   logic              pick_found;
   logic [ID_W-1:0]   pick_idx;
   logic [7:0]        sel_data;
   logic [3:0]        sel_cfg;
   logic [ID_W-1:0]   next_id;
   logic              tmo_hit;

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign sel_data  = req_data[8*int'(pick_idx) +: 8];
   assign sel_cfg   = req_cfg[4*int'(pick_idx) +: 4];
   assign next_id   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
   assign done_rise = done_s2_q & ~done_s3_q;

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt_q, tmo_cnt_d;

   // Abort fires on the edge where the counter would reach TIMEOUT_CYC.
   assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

   // Frame timer: cleared while granting, counts while the frame is outstanding.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == GRANT) begin
         tmo_cnt_d = '0;
      end else if (state_q == SEND || state_q == WAIT) begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
   end

   // Frame timer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tmo_cnt_q <= '0;
      else      tmo_cnt_q <= tmo_cnt_d;
   end
`else
   logic [15:0] unused_timeout;
   assign tmo_hit        = 1'b0;
   assign unused_timeout = 16'(TIMEOUT_CYC);
`endif

   // Bring PISO status from the baud domain into clk; extra done stage for edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_s1_q  <= 1'b0;
         act_s2_q  <= 1'b0;
         done_s1_q <= 1'b0;
         done_s2_q <= 1'b0;
         done_s3_q <= 1'b0;
      end else begin
         act_s1_q  <= tx_active;
         act_s2_q  <= act_s1_q;
         done_s1_q <= tx_done;
         done_s2_q <= done_s1_q;
         done_s3_q <= done_s2_q;
      end
   end

   // Next-state and next-output logic; outputs are registered so they change with the state.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      tx_send_d  = tx_send_q;
      tx_data_d  = tx_data_q;
      tx_par_d   = tx_par_q;
      tx_len_d   = tx_len_q;
      tx_stop_d  = tx_stop_q;
      busy_d     = busy_q;
      ack_d      = '0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) state_d = GRANT;
         end
         GRANT: begin
            if (pick_found) begin
               grant_id_d = pick_idx;
               tx_data_d  = sel_data;
               tx_par_d   = sel_cfg[CFG_PAR_LO +: 2];
               tx_stop_d  = sel_cfg[CFG_STOP];
               tx_len_d   = sel_cfg[CFG_LEN];
               tx_send_d  = 1'b1;
               busy_d     = 1'b1;
               state_d    = SEND;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         SEND, WAIT: begin
            // Completion wins over a coincident timeout so ack and err never overlap.
            if (done_rise) begin
               tx_send_d         = 1'b0;
               busy_d            = 1'b0;
               ack_d[grant_id_q] = 1'b1;
               ptr_d             = next_id;
               state_d           = RELEASE;
            end else if (tmo_hit) begin
               tx_send_d = 1'b0;
               busy_d    = 1'b0;
               err_d     = 1'b1;
               ptr_d     = next_id;
               state_d   = HOLDOFF;
            end else if (state_q == SEND && act_s2_q) begin
               state_d = WAIT;
            end
         end
         RELEASE: begin
            state_d = HOLDOFF;
         end
         HOLDOFF: begin
            if (!act_s2_q && !done_s2_q) state_d = IDLE;
         end
         default: begin
            tx_send_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // FSM and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_id_q <= '0;
         tx_send_q  <= 1'b0;
         tx_data_q  <= '0;
         tx_par_q   <= PAR_NONE;
         tx_len_q   <= 1'b0;
         tx_stop_q  <= 1'b0;
         busy_q     <= 1'b0;
         ack_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         tx_send_q  <= tx_send_d;
         tx_data_q  <= tx_data_d;
         tx_par_q   <= tx_par_d;
         tx_len_q   <= tx_len_d;
         tx_stop_q  <= tx_stop_d;
         busy_q     <= busy_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   assign ack            = ack_q;
   assign busy           = busy_q;
   assign grant_id       = grant_id_q;
   assign tx_send        = tx_send_q;
   assign tx_data        = tx_data_q;
   assign tx_parity_type = tx_par_q;
   assign tx_data_length = tx_len_q;
   assign tx_stop_bits   = tx_stop_q;
   assign err            = err_q;

endmodule
